// File: rtl/register_file_banked.sv
// Banked CPU register file: bypassed read ports, busy scoreboard, dedicated
// flags register (index R-1) and a one-deep shadow bank for context save/restore.
module register_file_banked #(
   parameter int L       = 16,
   parameter int A       = 3,
   parameter int ZeroReg = 1,
   parameter int Bypass  = 1
) (
   input  logic                  Clk,
   input  logic                  ResetN,
   input  logic                  WriteEnA,
   input  logic [A-1:0]          AddrA,
   input  logic [L-1:0]          InDataA,
   input  logic [A-1:0]          AddrB,
   input  logic [A-1:0]          AddrC,
   output logic [L-1:0]          OutDataB,
   output logic [L-1:0]          OutDataC,
   input  logic                  UpdateFlags,
   input  logic [L-1:0]          InNewFlags,
   output logic [L-1:0]          OutFlags,
   input  logic                  BusySet,
   input  logic [A-1:0]          BusyAddr,
   output logic                  BusyB,
   output logic                  BusyC,
   input  logic                  Save,
   input  logic                  Restore,
   output logic                  ShadowValid,
   output logic [L*(2**A)-1:0]   DebugData
);

   localparam int R = 2 ** A;
   localparam logic [A-1:0] FlagsIdx = A'(R - 1);

   logic [L-1:0] regs_q   [R];
   logic [L-1:0] regs_d   [R];
   logic [L-1:0] shadow_q [R];
   logic [L-1:0] shadow_d [R];
   logic [R-1:0] busy_q;
   logic [R-1:0] busy_d;
   logic         shadow_valid_q;
   logic         shadow_valid_d;

   logic         restore_eff;
   logic         wr_eff;
   logic         flags_eff;
   logic         set_eff;
   logic [A-1:0] rd_addr [2];
   logic [L-1:0] rd_data [2];
   logic         rd_busy [2];

   function automatic logic is_zero(input logic [A-1:0] a);
      return (ZeroReg != 0) && (a == '0);
   endfunction

   // A restore only takes effect with a saved context; it then swallows all other updates.
   always_comb begin
      restore_eff = Restore && shadow_valid_q;
      wr_eff      = WriteEnA && !restore_eff && !is_zero(AddrA);
      flags_eff   = UpdateFlags && !restore_eff;
      set_eff     = BusySet && !restore_eff && !is_zero(BusyAddr);
   end

   always_comb begin
      for (int i = 0; i < R; i++) begin
         regs_d[i]   = regs_q[i];
         shadow_d[i] = shadow_q[i];
      end
      busy_d         = busy_q;
      shadow_valid_d = shadow_valid_q;

      if (restore_eff) begin
         for (int i = 0; i < R; i++) regs_d[i] = shadow_q[i];
         busy_d         = '0;
         shadow_valid_d = 1'b0;
      end else begin
         if (Save) begin
            for (int i = 0; i < R; i++) shadow_d[i] = regs_q[i];
            shadow_valid_d = 1'b1;
         end
         if (wr_eff) begin
            regs_d[AddrA] = InDataA;
            busy_d[AddrA] = 1'b0;
         end
         // Flags path is applied after port A so it wins on a collision at R-1.
         if (flags_eff) begin
            regs_d[FlagsIdx] = InNewFlags;
            busy_d[FlagsIdx] = 1'b0;
         end
         if (set_eff) busy_d[BusyAddr] = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         for (int i = 0; i < R; i++) begin
            regs_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
         busy_q         <= '0;
         shadow_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < R; i++) begin
            regs_q[i]   <= regs_d[i];
            shadow_q[i] <= shadow_d[i];
         end
         busy_q         <= busy_d;
         shadow_valid_q <= shadow_valid_d;
      end
   end

   // Read ports: flags bypass beats port-A bypass; both are suppressed while restoring.
   always_comb begin
      rd_addr[0] = AddrB;
      rd_addr[1] = AddrC;
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = regs_q[rd_addr[p]];
         rd_busy[p] = busy_q[rd_addr[p]];
         if ((Bypass != 0) && !restore_eff) begin
            if (UpdateFlags && (rd_addr[p] == FlagsIdx)) begin
               rd_data[p] = InNewFlags;
               rd_busy[p] = 1'b0;
            end else if (WriteEnA && (AddrA == rd_addr[p])) begin
               rd_data[p] = InDataA;
               rd_busy[p] = 1'b0;
            end
         end
         if (is_zero(rd_addr[p]) || !ResetN) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < R; i++) DebugData[i*L +: L] = regs_q[i];
   end

   assign OutDataB    = rd_data[0];
   assign OutDataC    = rd_data[1];
   assign BusyB       = rd_busy[0];
   assign BusyC       = rd_busy[1];
   assign OutFlags    = regs_q[FlagsIdx];
   assign ShadowValid = shadow_valid_q;

endmodule

// File: doc/register_file_banked.md
Name: register_file_banked

Overview:
Next-generation CPU register file: parametrised width and depth, with write enable and an optional hardwired zero register. Adds write-to-read bypass, a per-register busy scoreboard for multi-cycle results, and a one-deep shadow bank for single-cycle context save/restore on interrupt entry/exit. The top register holds the flags and has a dedicated update path. Sits between decode (reads, busy check) and writeback (writes, flags).

Parameters:
L, 16, register width in bits
A, 3, address width; R = 2^A registers; flags register index = R-1
ZeroReg, 1, 1 = register 0 reads 0, writes and BusySet to it are ignored
Bypass, 1, 1 = same-cycle write data forwarded to read ports

Ports:
Clk  input  1  clock, all state updates on rising edge
ResetN  input  1  asynchronous active-low reset
WriteEnA  input  1  write enable for port A
AddrA  input  A  write address
InDataA  input  L  write data
AddrB  input  A  read address B
AddrC  input  A  read address C
OutDataB  output  L  read data B (combinational)
OutDataC  output  L  read data C (combinational)
UpdateFlags  input  1  write InNewFlags to register R-1
InNewFlags  input  L  new flags value
OutFlags  output  L  stored flags register (no bypass)
BusySet  input  1  mark BusyAddr pending
BusyAddr  input  A  register to mark pending
BusyB  output  1  register at AddrB pending
BusyC  output  1  register at AddrC pending
Save  input  1  copy all registers to shadow bank
Restore  input  1  copy shadow bank back to registers
ShadowValid  output  1  shadow bank holds a saved context
DebugData  output  L*R  all registers concatenated; register i at bits [i*L +: L]

Behaviour:
- Reset (ResetN low, async, independent of Clk): all registers, shadow bank, busy bits and ShadowValid cleared. All outputs 0 while reset is held. Reset mid-operation discards pending writes, busy bits and the saved context.
- Write: at rising edge, if WriteEnA, register AddrA <= InDataA. No write when WriteEnA=0.
- Zero register: when ZeroReg=1, reads of address 0 return 0. Writes to register 0 are dropped. Register 0 is never busy, and is never bypassed.
- Flags: UpdateFlags writes InNewFlags to register R-1. If WriteEnA also targets R-1 in the same cycle, UpdateFlags wins.
- Read: OutDataB/C are combinational from stored state, with zero-latency bypass when Bypass=1:
  - UpdateFlags and read address = R-1: return InNewFlags.
  - Otherwise, WriteEnA and AddrA = read address: return InDataA.
  - Bypass=0: stored value only; new data is visible the cycle after the edge.
  - No bypass during a cycle where Restore is effective.
- Busy scoreboard, one bit per register:
  - BusySet sets busy[BusyAddr].
  - A write via WriteEnA, or via UpdateFlags for R-1, clears that bit.
  - If set and clear hit the same address in the same cycle, set wins.
  - BusyB = busy[AddrB], forced 0 when Bypass=1 and the same-cycle write to AddrB is being forwarded. BusyC is defined the same way.
- Save (ShadowValid ignored): at the edge, shadow <= register values before that edge, and ShadowValid <= 1. A write in the same cycle still updates the live register but is not captured in the shadow. Busy bits are unaffected.
- Restore with ShadowValid=1: at the edge, all registers <= shadow, all busy bits cleared, ShadowValid <= 0. WriteEnA, UpdateFlags and BusySet in the same cycle are discarded.
- Restore with ShadowValid=0: ignored; normal operation proceeds.
- Save and Restore together: if ShadowValid=1, Restore wins and Save is ignored; otherwise Save acts.
- A second Save overwrites the shadow bank (one-deep, no nesting).
- DebugData reflects stored values only (no bypass).

Test Plan:
- Reset then write: ResetN pulsed low, write 0x1234 to r3; read r3 before the edge -> 0x1234 via bypass (Bypass=1); after the edge -> 0x1234 stored. DebugData[48+:16]=0x1234; all other fields 0.
- Zero register: write 0xFFFF to r0, BusySet r0 -> OutDataB for r0 = 0, BusyB=0, DebugData[15:0]=0.
- Flags priority: WriteEnA to r7 with 0x0001 and UpdateFlags with 0x0008 in the same cycle -> OutDataB(r7)=0x0008 combinationally; OutFlags=0x0008 after the edge.
- Scoreboard: BusySet r2 -> BusyB(r2)=1 next cycle. Write r2=0x00AA -> BusyB=0 and OutDataB=0x00AA in the write cycle; busy bit cleared after the edge. Write r2 plus BusySet r2 together -> still busy.
- Save/restore: r1=0x0011, Save, then write r1=0x0022 and r4=0x0044, Restore together with WriteEnA r5=0x0055 -> r1=0x0011, r4=0, r5=0, ShadowValid=0. A second Restore is ignored.
- Async reset mid-operation: Save, set busy r6, assert ResetN low between edges -> immediate all-zero registers, ShadowValid=0, BusyB=0.
